mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 256-bit, 10-cycle-latency data memory.
- Port 0 is the D-cache refill/write-back path; port 1 is the I-cache refill path.
- Serialises requests, latches address, data and direction for the whole transaction, drives the memory enable/write handshake, and returns a one-cycle ack plus registered read data to the winning requester.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 256, cache-line width

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-low reset
p0_req_i  input  1  port 0 request, level; held until p0_ack_o
p0_write_i  input  1  port 0 direction (1 = write)
p0_addr_i  input  ADDR_W  port 0 byte address
p0_data_i  input  DATA_W  port 0 write line
p0_ack_o  output  1  port 0 completion pulse
p0_data_o  output  DATA_W  port 0 read line
p1_req_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  same as port 0, for port 1
mem_enable_o  output  1  memory enable
mem_write_o  output  1  memory write select
mem_addr_o  output  ADDR_W  memory address
mem_data_o  output  DATA_W  memory write line
mem_ack_i  input  1  memory completion pulse
mem_data_i  input  DATA_W  memory read line, valid the cycle after mem_ack_i

Behaviour:
- State machine: IDLE, BUSY, RESP.
- Reset (rst_i == 0 at a clock edge), including mid-transaction:
  - state goes to IDLE.
  - All outputs go to 0: acks, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, p0_data_o, p1_data_o.
  - Round-robin pointer goes to port 1, so port 0 wins the first tie.
  - Any in-flight transaction is abandoned with no ack.
- IDLE:
  - If any req_i is high, pick a winner (see arbitration).
  - Latch the winner's addr, data and write into mem_addr_o, mem_data_o and mem_write_o.
  - Record the granted port, then go to BUSY.
  - With no request, stay in IDLE with mem_enable_o = 0.
- BUSY:
  - mem_enable_o = 1; latched address, data and write are held constant.
  - Requester inputs are ignored.
  - On mem_ack_i = 1, go to RESP.
- RESP:
  - mem_enable_o = 0 (this prevents the memory from restarting).
  - Pulse the granted port's ack_o for exactly one cycle.
  - On a read, the granted port's data_o <= mem_data_i at the same edge, so data_o is valid from the ack cycle onward.
  - On a write, data_o is unchanged.
  - The ungranted port's outputs are never touched.
  - Go to IDLE.
- Latency: req seen in cycle 0 gives ack_o high in cycle 12 (1 grant + 1 memory pickup + 10 memory wait).
  - Back-to-back transactions: next grant in IDLE at cycle 13, so 13-cycle throughput.
- Requester rule: deassert req_i the cycle after ack_o.
  - A req still high in the IDLE cycle after RESP is treated as a new request.
- data_o holds the last read line for that port until that port's next read completes.
- Arbitration, both requesting in IDLE:
  - Winner is per the Optional Feature.
  - A single requester always wins immediately.
- mem_ack_i outside BUSY is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; on a tie, grant the port not granted last.
  - Pointer updates on every grant.
- Undefined:
  - Fixed priority; port 0 wins every tie.
  - No pointer register is synthesised.
  - Port 1 can starve under continuous port 0 traffic; this is accepted.

Test Plan:
- Single read:
  - Stimulus: preload line at 0x0000_0040 = 256'hA5..A5; p0 read 0x40 in cycle 0.
  - Response: mem_enable_o high cycles 1-11; p0_ack_o pulse in cycle 12 only; p0_data_o = A5..A5; p1 outputs stay 0.
- Write then read:
  - Stimulus: p1 write 0x80 with 256'h1234...; then p1 read 0x80.
  - Response: second ack returns 256'h1234...; mem_write_o = 1 during the first BUSY only.
- Simultaneous requests:
  - Stimulus: p0 and p1 reads both in cycle 0, held until their acks.
  - Response: p0 ack at cycle 12, p1 ack at cycle 25.
  - With the macro, a second tie after that is granted to p0 (p1 was served last); without the macro, p0 again.
- Input change during BUSY:
  - Stimulus: alter p0_addr_i and p0_data_i in cycle 5 of a write to 0x100.
  - Response: memory line 0x100 holds the originally latched data.
- Reset mid-operation:
  - Stimulus: rst_i = 0 for 1 cycle at cycle 6 of a p0 read.
  - Response: all outputs 0 the next cycle; no p0_ack_o; a fresh request then completes in 12 cycles.
- Starvation check (macro undefined):
  - Stimulus: p0 requests continuously and p1 holds a request.
  - Response: p1 is never granted while p0 keeps requesting.
  - With the macro defined: grants alternate p0, p1, p0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter and sequencer in front of the shared
//               cache-line data memory. Port 0 serves the D-cache
//               refill/write-back path, port 1 the I-cache refill path.
//               One transaction at a time: the winner's address, data and
//               direction are latched for the whole transaction, the memory
//               enable is held until the memory acknowledges, then the
//               winner receives a one-cycle ack together with its read line.
//
// Ports       : clk_i          clock, all logic on the rising edge
//               rst_i          synchronous reset, active low
//               pN_req_i       request level, held until pN_ack_o
//               pN_write_i     direction, 1 = write
//               pN_addr_i      byte address
//               pN_data_i      write line
//               pN_ack_o       one-cycle completion pulse
//               pN_data_o      last read line returned to port N
//               mem_enable_o   memory enable (high while BUSY)
//               mem_write_o    memory write select
//               mem_addr_o     memory address
//               mem_data_o     memory write line
//               mem_ack_i      memory completion pulse
//               mem_data_i     memory read line, valid the cycle after ack
//
// Build macro : MEM_ARB_ROUND_ROBIN_EN
//               defined   -> round-robin on ties (port not granted last)
//               undefined -> fixed priority, port 0 wins every tie
//
// Revision    : 1.0 - initial release
//============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_grant_p1;   // port owning the current transaction
    logic              r_p0_ack;
    logic              r_p1_ack;
    logic [DATA_W-1:0] r_p0_data;
    logic [DATA_W-1:0] r_p1_data;

    logic              w_any_req;
    logic              w_pick_p1;

    assign w_any_req = p0_req_i | p1_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers which port was granted last; resets to port 1 so that
    // port 0 wins the first tie after reset.
    logic r_last_p1;

    assign w_pick_p1 = p1_req_i & (~p0_req_i | ~r_last_p1);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_last_p1 <= 1'b1;
        end else if ((r_state == c_ST_IDLE) && w_any_req) begin
            r_last_p1 <= w_pick_p1;
        end
    end
`else
    assign w_pick_p1 = p1_req_i & ~p0_req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= c_ST_IDLE;
            r_grant_p1   <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_data    <= '0;
            r_p1_data    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            // Acks are single-cycle pulses unless set below.
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_p1   <= w_pick_p1;
                        mem_addr_o   <= w_pick_p1 ? p1_addr_i  : p0_addr_i;
                        mem_data_o   <= w_pick_p1 ? p1_data_i  : p0_data_i;
                        mem_write_o  <= w_pick_p1 ? p1_write_i : p0_write_i;
                        mem_enable_o <= 1'b1;
                        r_state      <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    // Latched request fields are held; requester inputs are
                    // not looked at until the next IDLE.
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        if (r_grant_p1) begin
                            r_p1_ack <= 1'b1;
                        end else begin
                            r_p0_ack <= 1'b1;
                        end
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    // The read line arrives during this cycle; capture it so
                    // data_o keeps it after the ack.
                    if (!mem_write_o) begin
                        if (r_grant_p1) begin
                            r_p1_data <= mem_data_i;
                        end else begin
                            r_p0_data <= mem_data_i;
                        end
                    end
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    mem_enable_o <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign p0_ack_o = r_p0_ack;
    assign p1_ack_o = r_p1_ack;

    // During the ack cycle of a read the memory line is forwarded directly,
    // so data_o is already valid while ack_o is high.
    assign p0_data_o = (r_p0_ack && !mem_write_o) ? mem_data_i : r_p0_data;
    assign p1_data_o = (r_p1_ack && !mem_write_o) ? mem_data_i : r_p1_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               behavioural 10-cycle-latency line memory.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    localparam logic [DATA_W-1:0] c_LINE_A5 = {32{8'hA5}};
    localparam logic [DATA_W-1:0] c_LINE_W1 = {8{32'h12345678}};
    localparam logic [DATA_W-1:0] c_LINE_W2 = {8{32'hCAFEF00D}};
    localparam logic [DATA_W-1:0] c_LINE_W3 = {8{32'h0BADC0DE}};
    localparam logic [DATA_W-1:0] c_JUNK    = {8{32'hDEADBEEF}};

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              p0_req_i, p0_write_i, p1_req_i, p1_write_i;
    logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
    logic [DATA_W-1:0] p0_data_i, p1_data_i;
    logic              p0_ack_o, p1_ack_o;
    logic [DATA_W-1:0] p0_data_o, p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p0_req_i    (p0_req_i),
        .p0_write_i  (p0_write_i),
        .p0_addr_i   (p0_addr_i),
        .p0_data_i   (p0_data_i),
        .p0_ack_o    (p0_ack_o),
        .p0_data_o   (p0_data_o),
        .p1_req_i    (p1_req_i),
        .p1_write_i  (p1_write_i),
        .p1_addr_i   (p1_addr_i),
        .p1_data_i   (p1_data_i),
        .p1_ack_o    (p1_ack_o),
        .p1_data_o   (p1_data_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i)
    );

    // Line memory: picks up the enable, acks 10 cycles later, performs the
    // access with the address/data presented in the ack cycle and drives
    // the read line only in the following cycle.
    logic [DATA_W-1:0] mem [0:31];
    logic              m_busy = 1'b0;
    int                m_cnt  = 0;

    always @(posedge clk_i) begin
        mem_ack_i  <= 1'b0;
        mem_data_i <= c_JUNK;
        if (!rst_i) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            mem[2]  <= c_LINE_A5;
        end else if (m_busy) begin
            if (m_cnt == 9) begin
                m_busy <= 1'b0;
                if (mem_write_o) mem[mem_addr_o[9:5]] <= mem_data_o;
                else             mem_data_i <= mem[mem_addr_o[9:5]];
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 8) mem_ack_i <= 1'b1;
            end
        end else if (mem_enable_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on one port. lat is the cycle of the ack counted from
    // the cycle in which the request is first seen (-1 on timeout).
    task automatic do_txn(input int port, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit chg,
                          input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cdata,
                          output int lat, output int en_cnt, output int other_acks,
                          output logic wr_mid, output logic [ADDR_W-1:0] addr_mid);
        @(negedge clk_i);
        if (port == 0) begin
            p0_req_i = 1'b1; p0_write_i = wr; p0_addr_i = addr; p0_data_i = data;
        end else begin
            p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = data;
        end
        lat = -1; en_cnt = 0; other_acks = 0; wr_mid = 1'b0; addr_mid = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) en_cnt++;
            if ((port == 0) ? p1_ack_o : p0_ack_o) other_acks++;
            if (chg && c == 5) begin
                if (port == 0) begin p0_addr_i = caddr; p0_data_i = cdata; end
                else           begin p1_addr_i = caddr; p1_data_i = cdata; end
            end
            if (c == 6) begin wr_mid = mem_write_o; addr_mid = mem_addr_o; end
            if ((port == 0) ? p0_ack_o : p1_ack_o) begin
                lat = c;
                p0_req_i = 1'b0; p1_req_i = 1'b0;
                break;
            end
        end
        p0_req_i = 1'b0; p1_req_i = 1'b0;
    endtask

    // Both ports read in the same cycle; each drops its request on its ack.
    task automatic do_tie(input string tag);
        int l0, l1;
        @(negedge clk_i);
        p0_req_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h40;
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h80;
        l0 = -1; l1 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (p0_ack_o && l0 < 0) begin
                l0 = c; p0_req_i = 1'b0;
                check({tag, " p0 data"}, p0_data_o, c_LINE_A5);
            end
            if (p1_ack_o && l1 < 0) begin
                l1 = c; p1_req_i = 1'b0;
                check({tag, " p1 data"}, p1_data_o, c_LINE_W1);
            end
            if (l0 >= 0 && l1 >= 0) break;
        end
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        check({tag, " p0 ack cycle"}, DATA_W'(l0), DATA_W'(12));
        check({tag, " p1 ack cycle"}, DATA_W'(l1), DATA_W'(25));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " p0_ack"},  DATA_W'(p0_ack_o),     '0);
        check({tag, " p1_ack"},  DATA_W'(p1_ack_o),     '0);
        check({tag, " enable"},  DATA_W'(mem_enable_o), '0);
        check({tag, " write"},   DATA_W'(mem_write_o),  '0);
        check({tag, " addr"},    DATA_W'(mem_addr_o),   '0);
        check({tag, " wdata"},   mem_data_o,            '0);
        check({tag, " p0_data"}, p0_data_o,             '0);
        check({tag, " p1_data"}, p1_data_o,             '0);
    endtask

    initial begin
        int lat, en_cnt, oth, n0, n1, k;
        int ord [4];
        logic wr_mid;
        logic [ADDR_W-1:0] addr_mid;
        int exp_n1;
        int exp_ord [3];

        rst_i = 1'b0;
        p0_req_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b1;

        // Single read on port 0
        do_txn(0, 1'b0, 32'h40, '0, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("rd0 latency",       DATA_W'(lat),          DATA_W'(12));
        check("rd0 enable cycles", DATA_W'(en_cnt),       DATA_W'(11));
        check("rd0 p1 acks",       DATA_W'(oth),          '0);
        check("rd0 p0 data",       p0_data_o,             c_LINE_A5);
        check("rd0 p1 data",       p1_data_o,             '0);
        check("rd0 enable at ack", DATA_W'(mem_enable_o), '0);
        @(negedge clk_i);
        check("rd0 ack one cycle", DATA_W'(p0_ack_o),     '0);
        check("rd0 data held",     p0_data_o,             c_LINE_A5);

        // Write then read on port 1
        do_txn(1, 1'b1, 32'h80, c_LINE_W1, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("wr1 latency",       DATA_W'(lat),    DATA_W'(12));
        check("wr1 write in busy", DATA_W'(wr_mid), DATA_W'(1));
        check("wr1 p1 data kept",  p1_data_o,       '0);
        do_txn(1, 1'b0, 32'h80, '0, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("rd1 latency",       DATA_W'(lat),    DATA_W'(12));
        check("rd1 write in busy", DATA_W'(wr_mid), '0);
        check("rd1 p1 data",       p1_data_o,       c_LINE_W1);
        check("rd1 p0 untouched",  p0_data_o,       c_LINE_A5);

        // Simultaneous requests, twice (port 0 wins both in either build)
        do_tie("tie1");
        do_tie("tie2");

        // Requester inputs change while BUSY
        do_txn(0, 1'b1, 32'h100, c_LINE_W2, 1'b1, 32'h140, c_LINE_W3,
               lat, en_cnt, oth, wr_mid, addr_mid);
        check("chg latency",   DATA_W'(lat),      DATA_W'(12));
        check("chg addr held", DATA_W'(addr_mid), DATA_W'(32'h100));
        do_txn(0, 1'b0, 32'h100, '0, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("chg readback",  p0_data_o,         c_LINE_W2);

        // Reset in cycle 6 of a port 0 read
        @(negedge clk_i);
        p0_req_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h40;
        repeat (6) @(negedge clk_i);
        rst_i = 1'b0; p0_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        check_all_zero("midrst");
        n0 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (p0_ack_o) n0++;
        end
        check("midrst no ack", DATA_W'(n0), '0);
        do_txn(0, 1'b0, 32'h40, '0, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("midrst fresh latency", DATA_W'(lat), DATA_W'(12));
        check("midrst fresh data",    p0_data_o,    c_LINE_A5);

        // Port 1 served last, then continuous port 0 traffic vs held port 1
        do_txn(1, 1'b0, 32'h80, '0, 1'b0, '0, '0, lat, en_cnt, oth, wr_mid, addr_mid);
        check("pre-starve latency", DATA_W'(lat), DATA_W'(12));
        @(negedge clk_i);
        p0_req_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h40;
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h80;
        n0 = 0; n1 = 0; k = 0;
        ord = '{-1, -1, -1, -1};
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk_i);
            if (p0_ack_o) begin
                n0++;
                if (k < 4) begin ord[k] = 0; k++; end
            end
            if (p1_ack_o) begin
                n1++; p1_req_i = 1'b0;
                if (k < 4) begin ord[k] = 1; k++; end
            end
        end
        p0_req_i = 1'b0; p1_req_i = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_n1 = 1;
        exp_ord = '{0, 1, 0};
`else
        exp_n1 = 0;
        exp_ord = '{0, 0, 0};
`endif
        check("starve p1 grants", DATA_W'(n1), DATA_W'(exp_n1));
        check("starve total",     DATA_W'(n0 + n1), DATA_W'(4));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("starve grant %0d", i), DATA_W'(ord[i]), DATA_W'(exp_ord[i]));
        end

        repeat (15) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
